// File: rtl/stump_control_seq.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencing, instruction register and decode.
// Adds a memory wait-state handshake with a bus-timeout trap, a HALT instruction with
// run/resume, and drives every don't-care decode field to 0.
module stump_control_seq #(
    parameter logic [2:0] PC_REG    = 3'd7,
    parameter int         TIMEOUT_W = 4,
    parameter bit         HALT_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    input  logic [3:0]  cc,
    output logic [15:0] ir,
    output logic        fetch,
    output logic        execute,
    output logic        memory,
    output logic        halted,
    output logic        bus_err,
    output logic        ext_op,
    output logic        reg_write,
    output logic [2:0]  dest,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [1:0]  shift_op,
    output logic        opB_mux_sel,
    output logic [2:0]  alu_func,
    output logic        cc_en,
    output logic        mem_ren,
    output logic        mem_wen
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXECUTE,
        S_MEMORY,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [2:0]           OP_LDST   = 3'b110;
    localparam logic [2:0]           OP_BCC    = 3'b111;
    localparam logic [2:0]           ALU_ADD   = 3'b000;
    localparam logic [15:0]          HALT_INSN = 16'hE1FF;
    localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;

    state_t               state;
    state_t               state_next;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 waiting;
    logic                 timed_out;
    logic [2:0]           opcode;
    logic                 is_imm;
    logic                 is_store;
    logic                 is_halt;
    logic                 branch_taken;
    logic                 flag_n;
    logic                 flag_z;
    logic                 flag_v;
    logic                 flag_c;

    assign opcode   = ir[15:13];
    assign is_imm   = ir[12];
    assign is_store = ir[11];
    assign is_halt  = HALT_EN && (ir == HALT_INSN);

    assign flag_n = cc[3];
    assign flag_z = cc[2];
    assign flag_v = cc[1];
    assign flag_c = cc[0];

    // A memory access is outstanding whenever the sequencer sits in FETCH or MEMORY without ready.
    assign waiting   = ((state == S_FETCH) || (state == S_MEMORY)) && !mem_ready;
    assign timed_out = waiting && (wait_cnt == WAIT_MAX);

    // Evaluate the branch condition field ir[11:8] against the {N,Z,V,C} flags.
    always_comb begin
        branch_taken = 1'b0;
        case (ir[11:8])
            4'b0000: branch_taken = 1'b1;                                  // AL
            4'b0001: branch_taken = 1'b0;                                  // NV
            4'b0010: branch_taken = !flag_c && !flag_z;                    // HI
            4'b0011: branch_taken = flag_c || flag_z;                      // LS
            4'b0100: branch_taken = !flag_c;                               // CC
            4'b0101: branch_taken = flag_c;                                // CS
            4'b0110: branch_taken = !flag_z;                               // NE
            4'b0111: branch_taken = flag_z;                                // EQ
            4'b1000: branch_taken = !flag_v;                               // VC
            4'b1001: branch_taken = flag_v;                                // VS
            4'b1010: branch_taken = !flag_n;                               // PL
            4'b1011: branch_taken = flag_n;                                // MI
            4'b1100: branch_taken = (flag_n == flag_v);                    // GE
            4'b1101: branch_taken = (flag_n != flag_v);                    // LT
            4'b1110: branch_taken = !flag_z && (flag_n == flag_v);         // GT
            4'b1111: branch_taken = flag_z || (flag_n != flag_v);          // LE
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state selection; a ready on the timeout cycle completes the access instead of trapping.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_EXECUTE;
                end else if (timed_out) begin
                    state_next = S_ERROR;
                end
            end
            S_EXECUTE: begin
                if (is_halt) begin
                    state_next = S_HALT;
                end else if (opcode == OP_LDST) begin
                    state_next = S_MEMORY;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timed_out) begin
                    state_next = S_ERROR;
                end
            end
            S_HALT: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_ERROR: begin
                state_next = S_ERROR;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register captures the fetched word when the fetch completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= 16'h0000;
        end else if ((state == S_FETCH) && mem_ready) begin
            ir <= mem_rdata;
        end
    end

    // Consecutive not-ready counter: cleared on any state change, saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (waiting && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Decode: outputs depend only on state, ir, cc and mem_ready; everything not driven stays 0.
    always_comb begin
        fetch       = 1'b0;
        execute     = 1'b0;
        memory      = 1'b0;
        halted      = 1'b0;
        bus_err     = 1'b0;
        ext_op      = 1'b0;
        reg_write   = 1'b0;
        dest        = 3'd0;
        srcA        = 3'd0;
        srcB        = 3'd0;
        shift_op    = 2'd0;
        opB_mux_sel = 1'b0;
        alu_func    = 3'd0;
        cc_en       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        case (state)
            S_FETCH: begin
                fetch    = 1'b1;
                mem_ren  = 1'b1;
                srcA     = PC_REG;
                alu_func = ALU_ADD;
                if (mem_ready) begin
                    reg_write = 1'b1;
                    dest      = PC_REG;
                end
            end
            S_EXECUTE: begin
                execute = 1'b1;
                if (is_halt) begin
                    reg_write = 1'b0;
                end else if (opcode == OP_BCC) begin
                    ext_op      = 1'b1;
                    opB_mux_sel = 1'b1;
                    srcA        = PC_REG;
                    dest        = PC_REG;
                    alu_func    = ALU_ADD;
                    reg_write   = branch_taken;
                end else begin
                    dest = ir[10:8];
                    srcA = ir[7:5];
                    if (is_imm) begin
                        opB_mux_sel = 1'b1;
                    end else begin
                        srcB     = ir[4:2];
                        shift_op = ir[1:0];
                    end
                    if (opcode == OP_LDST) begin
                        alu_func = ALU_ADD;
                    end else begin
                        alu_func  = opcode;
                        reg_write = 1'b1;
                        cc_en     = 1'b1;
                    end
                end
            end
            S_MEMORY: begin
                memory = 1'b1;
                if (is_store) begin
                    mem_wen = 1'b1;
                    srcA    = ir[10:8];
                end else begin
                    mem_ren   = 1'b1;
                    dest      = ir[10:8];
                    reg_write = mem_ready;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERROR: begin
                bus_err = 1'b1;
            end
            default: begin
                fetch = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control_seq.sv
// Testbench for stump_control_seq: two instances (halt recognised / not recognised) share
// the stimulus; an instruction-level model predicts every output each cycle.
module tb_stump_control_seq;

    localparam int MAX_WAITS = 15;

    localparam logic [7:0] P_FETCH = 8'd10;
    localparam logic [7:0] P_EXEC  = 8'd20;
    localparam logic [7:0] P_MEM   = 8'd30;
    localparam logic [7:0] P_HALT  = 8'd40;
    localparam logic [7:0] P_ERR   = 8'd50;

    typedef struct packed {
        logic        fetch;
        logic        execute;
        logic        memory;
        logic        halted;
        logic        bus_err;
        logic        ext_op;
        logic        reg_write;
        logic [2:0]  dest;
        logic [2:0]  src_a;
        logic [2:0]  src_b;
        logic [1:0]  shift_op;
        logic        opb_sel;
        logic [2:0]  alu_func;
        logic        cc_en;
        logic        mem_ren;
        logic        mem_wen;
        logic [15:0] ir;
    } obs_t;

    typedef struct packed {
        logic [7:0]  ph;
        logic [7:0]  waits;
        logic [15:0] ir;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [3:0]  cc = 4'h0;

    logic [1:0][15:0] ir_o;
    logic [1:0]       fetch_o, execute_o, memory_o, halted_o, bus_err_o, ext_op_o, reg_write_o;
    logic [1:0][2:0]  dest_o, srca_o, srcb_o, alu_o;
    logic [1:0][1:0]  shift_o;
    logic [1:0]       opb_o, cc_en_o, mem_ren_o, mem_wen_o;

    int   tests_run = 0;
    int   tests_failed = 0;
    logic check_en = 1'b0;

    obs_t    act [2];
    mstate_t m   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        stump_control_seq #(
            .PC_REG   (3'd7),
            .TIMEOUT_W(4),
            .HALT_EN  (g == 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .run        (run),
            .mem_ready  (mem_ready),
            .mem_rdata  (mem_rdata),
            .cc         (cc),
            .ir         (ir_o[g]),
            .fetch      (fetch_o[g]),
            .execute    (execute_o[g]),
            .memory     (memory_o[g]),
            .halted     (halted_o[g]),
            .bus_err    (bus_err_o[g]),
            .ext_op     (ext_op_o[g]),
            .reg_write  (reg_write_o[g]),
            .dest       (dest_o[g]),
            .srcA       (srca_o[g]),
            .srcB       (srcb_o[g]),
            .shift_op   (shift_o[g]),
            .opB_mux_sel(opb_o[g]),
            .alu_func   (alu_o[g]),
            .cc_en      (cc_en_o[g]),
            .mem_ren    (mem_ren_o[g]),
            .mem_wen    (mem_wen_o[g])
        );
    end

    // 10-unit clock.
    always #5 clk = ~clk;

    // Gather each instance's outputs into one record for comparison.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            act[k]           = '0;
            act[k].fetch     = fetch_o[k];
            act[k].execute   = execute_o[k];
            act[k].memory    = memory_o[k];
            act[k].halted    = halted_o[k];
            act[k].bus_err   = bus_err_o[k];
            act[k].ext_op    = ext_op_o[k];
            act[k].reg_write = reg_write_o[k];
            act[k].dest      = dest_o[k];
            act[k].src_a     = srca_o[k];
            act[k].src_b     = srcb_o[k];
            act[k].shift_op  = shift_o[k];
            act[k].opb_sel   = opb_o[k];
            act[k].alu_func  = alu_o[k];
            act[k].cc_en     = cc_en_o[k];
            act[k].mem_ren   = mem_ren_o[k];
            act[k].mem_wen   = mem_wen_o[k];
            act[k].ir        = ir_o[k];
        end
    end

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, v, c, base;
        n = flags[3]; z = flags[2]; v = flags[1]; c = flags[0];
        case (cond[3:1])
            3'd0:    base = 1'b1;
            3'd1:    base = !c && !z;
            3'd2:    base = !c;
            3'd3:    base = !z;
            3'd4:    base = !v;
            3'd5:    base = !n;
            3'd6:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic obs_t exp_obs(input mstate_t s, input logic [3:0] flags,
                                     input logic rdy, input bit halt_en);
        obs_t o;
        logic [2:0] op;
        o    = '0;
        o.ir = s.ir;
        op   = s.ir[15:13];
        if (s.ph == P_FETCH) begin
            o.fetch = 1'b1; o.mem_ren = 1'b1; o.src_a = 3'd7;
            if (rdy) begin o.reg_write = 1'b1; o.dest = 3'd7; end
        end else if (s.ph == P_EXEC) begin
            o.execute = 1'b1;
            if (halt_en && s.ir == 16'hE1FF) begin
                o.execute = 1'b1;
            end else if (op == 3'd7) begin
                o.ext_op = 1'b1; o.opb_sel = 1'b1; o.src_a = 3'd7; o.dest = 3'd7;
                o.reg_write = cond_holds(s.ir[11:8], flags);
            end else begin
                o.dest = s.ir[10:8]; o.src_a = s.ir[7:5];
                if (s.ir[12]) o.opb_sel = 1'b1;
                else begin o.src_b = s.ir[4:2]; o.shift_op = s.ir[1:0]; end
                if (op != 3'd6) begin o.reg_write = 1'b1; o.cc_en = 1'b1; o.alu_func = op; end
            end
        end else if (s.ph == P_MEM) begin
            o.memory = 1'b1;
            if (s.ir[11]) begin o.mem_wen = 1'b1; o.src_a = s.ir[10:8]; end
            else begin o.mem_ren = 1'b1; o.dest = s.ir[10:8]; o.reg_write = rdy; end
        end else if (s.ph == P_HALT) begin
            o.halted = 1'b1;
        end else begin
            o.bus_err = 1'b1;
        end
        return o;
    endfunction

    function automatic mstate_t next_model(input mstate_t s, input logic rdy, input logic [15:0] data,
                                           input logic go, input bit halt_en);
        mstate_t n;
        n = s;
        if (s.ph == P_FETCH || s.ph == P_MEM) begin
            if (rdy) begin
                n.waits = 0;
                if (s.ph == P_FETCH) begin n.ph = P_EXEC; n.ir = data; end
                else n.ph = P_FETCH;
            end else if (int'(s.waits) >= MAX_WAITS) begin
                n.ph = P_ERR; n.waits = 0;
            end else begin
                n.waits = s.waits + 8'd1;
            end
        end else if (s.ph == P_EXEC) begin
            n.waits = 0;
            if (halt_en && s.ir == 16'hE1FF) n.ph = P_HALT;
            else if (s.ir[15:13] == 3'd6)    n.ph = P_MEM;
            else                             n.ph = P_FETCH;
        end else if (s.ph == P_HALT) begin
            if (go) n.ph = P_FETCH;
        end
        return n;
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) m[k] <= '{ph: P_FETCH, waits: 8'd0, ir: 16'h0000};
            else     m[k] <= next_model(m[k], mem_ready, mem_rdata, run, k == 0);
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Compare both instances against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                check_output(k == 0 ? "model halt_en=1" : "model halt_en=0",
                             64'(act[k]), 64'(exp_obs(m[k], cc, mem_ready, k == 0)));
            end
        end
    end

    task automatic apply_stimulus(input logic rdy, input logic [15:0] data,
                                  input logic [3:0] flags, input logic go);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        mem_rdata = data;
        cc        = flags;
        run       = go;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        mem_ready = 1'b0;
        run = 1'b0;
        #4;
        rst = 1'b0;
    endtask

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        logic        rdy;
        logic [15:0] data;
        int          burst;
        int          pick;
        burst = 0;
        m[0] = '{ph: P_FETCH, waits: 8'd0, ir: 16'h0000};
        m[1] = '{ph: P_FETCH, waits: 8'd0, ir: 16'h0000};
        #1 rst = 1'b1;
        check_en = 1'b1;
        #11 rst = 1'b0;
        #1;
        check_output("reset fetch", act[0].fetch, 1);
        check_output("reset ir", act[0].ir, 0);
        check_output("reset mem_ren", act[0].mem_ren, 1);
        check_output("reset halted/bus_err", {act[0].halted, act[0].bus_err}, 0);

        apply_stimulus(1'b1, 16'h0123, 4'h0, 1'b0);
        check_output("fetch pc write", {act[0].reg_write, act[0].dest}, {1'b1, 3'd7});
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("add exec state", act[0].execute, 1);
        check_output("add exec regs", {act[0].dest, act[0].src_a, act[0].src_b, act[0].shift_op},
                     {3'd1, 3'd1, 3'd0, 2'd3});
        check_output("add exec enables", {act[0].reg_write, act[0].cc_en, act[0].opb_sel}, 3'b110);
        apply_stimulus(1'b1, 16'hD245, 4'h0, 1'b0);
        check_output("back to fetch", act[0].fetch, 1);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("ld exec", {act[0].reg_write, act[0].cc_en, act[0].opb_sel, act[0].dest},
                     {3'b001, 3'd2});
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
            check_output("ld wait", {act[0].memory, act[0].mem_ren, act[0].reg_write, act[0].dest},
                         {3'b110, 3'd2});
        end
        apply_stimulus(1'b1, 16'h0000, 4'h0, 1'b0);
        check_output("ld done", {act[0].memory, act[0].mem_ren, act[0].reg_write, act[0].dest},
                     {3'b111, 3'd2});

        apply_stimulus(1'b1, 16'hE600, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 4'b0100, 1'b0);
        check_output("bne z=1", {act[0].execute, act[0].reg_write, act[0].cc_en, act[0].ext_op}, 4'b1001);
        apply_stimulus(1'b1, 16'hE600, 4'b0100, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 4'b0000, 1'b0);
        check_output("bne z=0", {act[0].reg_write, act[0].cc_en, act[0].dest}, {2'b10, 3'd7});

        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        apply_stimulus(1'b1, 16'h0123, 4'h0, 1'b0);
        check_output("ready at limit", {act[0].fetch, act[0].bus_err, act[0].reg_write}, 3'b101);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("no trap", act[0].execute, 1);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("last wait", {act[0].fetch, act[0].bus_err}, 2'b10);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("timeout trap", {act[0].fetch, act[0].bus_err, act[0].mem_ren, act[0].reg_write}, 4'b0100);
        apply_stimulus(1'b1, 16'h0123, 4'h0, 1'b1);
        check_output("error sticky", {act[0].bus_err, act[0].fetch}, 2'b10);

        do_reset();
        apply_stimulus(1'b1, 16'hE1FF, 4'h0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("halt exec", {act[0].execute, act[0].reg_write, act[1].execute, act[1].reg_write}, 4'b1010);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("halted", {act[0].halted, act[0].fetch, act[0].mem_ren}, 3'b100);
        check_output("no halt variant", {act[1].halted, act[1].fetch}, 2'b01);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b1);
        check_output("run pending", act[0].halted, 1);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("resumed", {act[0].halted, act[0].fetch}, 2'b01);

        do_reset();
        apply_stimulus(1'b1, 16'hC9E0, 4'h0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        check_output("store", {act[0].mem_wen, act[0].mem_ren, act[0].src_a}, {2'b10, 3'd1});
        #1 rst = 1'b1;
        #1;
        check_output("rst drops wen", {act[0].mem_wen, act[0].fetch, act[0].ir}, {2'b01, 16'h0000});
        apply_stimulus(1'b0, 16'h0000, 4'h0, 1'b0);
        rst = 1'b0;
        #1;
        check_output("after rst", {act[0].fetch, act[0].ir}, {1'b1, 16'h0000});

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (burst > 0) begin
                rdy = 1'b0;
                burst--;
            end else if ($urandom_range(0, 299) == 0) begin
                burst = $urandom_range(12, 20);
                rdy = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 9) < 7);
            end
            pick = $urandom_range(0, 7);
            if (pick == 0)      data = 16'hE1FF;
            else if (pick == 1) data = {3'b110, 13'($urandom)};
            else                data = 16'($urandom);
            apply_stimulus(rdy, data, 4'($urandom), $urandom_range(0, 5) == 0);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
